mcycle_unit: RTL and testbench
==============================

// Module: mcycle_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide unit; responder to the decoder's Start/MCycleOp request.
//  Decoder raises Start for MUL/DIV-class instructions; this block computes and holds Busy to stall the pipeline.
//  Datapath feeds Operand1/Operand2 and writes back Result1/Result2 once Busy falls.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
// PORTS
//  CLK       in   1      clock, rising edge
//  RESET     in   1      asynchronous, active-high reset
//  Start     in   1      request; sampled only in IDLE
//  MCycleOp  in   2      00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
//  Operand1  in   WIDTH  multiplicand / dividend
//  Operand2  in   WIDTH  multiplier / divisor
//  Result1   out  WIDTH  mul: product[WIDTH-1:0]; div: quotient
//  Result2   out  WIDTH  mul: product[2*WIDTH-1:WIDTH]; div: remainder
//  Busy      out  1      operation in progress; stall while high
// BEHAVIOUR
//  - One clock (CLK); reset asynchronous, active-high (RESET). Reset: state IDLE, Result1=0, Result2=0, Busy=0,
//    counter=0, all internal regs 0. Reset mid-operation aborts; Busy drops immediately; no result written.
//  - FSM: IDLE -> COMPUTING on edge where Start=1; COMPUTING -> IDLE on edge completing final iteration.
//  - Busy = (IDLE & Start) | COMPUTING (combinational: high in the Start cycle itself).
//  - On Start edge: latch MCycleOp; convert operands to magnitudes (signed ops: |x|, two's complement);
//    record result signs; counter=0.
//  - Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
//  - Divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
//  - Latency: WIDTH iterations after Start edge; Busy high exactly WIDTH+1 cycles; Result1/Result2 updated
//    on final edge and valid from the first cycle Busy=0.
//  - Sign fix-up on final edge: product negated if operand signs differ (signed mul); quotient negative if
//    signs differ, remainder takes dividend sign (signed div). All arithmetic wraps modulo 2^WIDTH.
//  - Division by zero: Result1 = all ones, Result2 = Operand1 (latched value), same latency, no error flag.
//  - Signed overflow (most-negative / -1): Result1 = most-negative value, Result2 = 0.
//  - Start while COMPUTING ignored; operand changes after Start edge ignored.
//  - Start held high on the completion edge is not sampled; a new op needs Start high in a cycle while IDLE.
//  - Results hold until next completion or reset; Start alone does not disturb them.
// CONFIGURATION
//  - MCYCLE_EARLY_TERM_EN defined: multiply completes on the edge after which the remaining (shifted)
//    multiplier magnitude is zero, minimum 1 iteration; Busy high (iterations+1) cycles.
//    Divide latency unchanged.
//  - Undefined: all ops take fixed WIDTH iterations as above.
// TESTING (WIDTH=32)
//  - Unsigned mul: Op=01, 0xFFFFFFFF*0xFFFFFFFF -> Result2=0xFFFFFFFE, Result1=0x00000001; Busy high 33 cycles.
//  - Signed mul: Op=00, -3*7 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB;
//    with MCYCLE_EARLY_TERM_EN, 5*1 -> Busy high 2 cycles.
//  - Signed div: Op=10, -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF;
//    0x80000000/-1 -> Result1=0x80000000, Result2=0.
//  - Unsigned div by zero: Op=11, 100/0 -> Result1=0xFFFFFFFF, Result2=100 after 33 Busy cycles.
//  - Start re-pulsed mid-op with new operands -> ignored, original result returned;
//    RESET at cycle 10 -> Busy=0, results 0 immediately.
//  - Back-to-back: Start asserted first IDLE cycle after completion -> second op starts; first result visible 1 cycle.

Source files
------------

// File: rtl/mcycle_unit.sv
// rtl/mcycle_unit.sv - iterative shift-add multiplier / restoring divider with Busy stall.
// Optional MCYCLE_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are all zero.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, COMPUTING = 1'b1} state_t;

  state_t               state_q;
  logic                 is_div_q, neg_q, rem_neg_q;
  logic [CW-1:0]        count_q;
  logic [WIDTH-1:0]     op1_q, mplier_q, quot_q, rem_q, result1_q, result2_q;
  logic [2*WIDTH-1:0]   mcand_q, acc_q;

  logic                 is_signed, s1, s2, last;
  logic [WIDTH-1:0]     mag1, mag2, mplier_d, quot_d, quot_fix, rem_d, rem_fix;
  logic [2*WIDTH-1:0]   acc_d, mcand_d, prod_fix;
  logic [WIDTH:0]       shifted, trial;

  assign is_signed = ~MCycleOp[0];
  assign s1        = is_signed & Operand1[WIDTH-1];
  assign s2        = is_signed & Operand2[WIDTH-1];
  assign mag1      = s1 ? -Operand1 : Operand1;
  assign mag2      = s2 ? -Operand2 : Operand2;

  assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mcand_d  = mcand_q << 1;
  assign mplier_d = mplier_q >> 1;

  // Partial remainder is bounded by the divisor, so only the trial subtraction needs the extra bit.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, mplier_q};
  assign rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quot_d  = {quot_q[WIDTH-2:0], ~trial[WIDTH]};

  assign prod_fix = neg_q ? -acc_d : acc_d;
  assign quot_fix = neg_q ? -quot_d : quot_d;
  assign rem_fix  = rem_neg_q ? -rem_d : rem_d;

`ifdef MCYCLE_EARLY_TERM_EN
  assign last = (count_q == CW'(WIDTH - 1)) || (!is_div_q && (mplier_d == '0));
`else
  assign last = (count_q == CW'(WIDTH - 1));
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      count_q   <= '0;
      op1_q     <= '0;
      mplier_q  <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_q   <= COMPUTING;
            is_div_q  <= MCycleOp[1];
            neg_q     <= s1 ^ s2;
            rem_neg_q <= s1;
            count_q   <= '0;
            op1_q     <= Operand1;
            mplier_q  <= mag2;
            quot_q    <= mag1;
            rem_q     <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, mag1};
            acc_q     <= '0;
          end
        end
        COMPUTING: begin
          count_q <= count_q + 1'b1;
          if (is_div_q) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
          end
          if (last) begin
            state_q <= IDLE;
            if (!is_div_q) begin
              result1_q <= prod_fix[WIDTH-1:0];
              result2_q <= prod_fix[2*WIDTH-1:WIDTH];
            end else if (mplier_q == '0) begin
              // Divide by zero reports all-ones quotient and the untouched dividend.
              result1_q <= '1;
              result2_q <= op1_q;
            end else begin
              result1_q <= quot_fix;
              result2_q <= rem_fix;
            end
          end
        end
      endcase
    end
  end

  assign Busy    = ((state_q == IDLE) & Start) | (state_q == COMPUTING);
  assign Result1 = result1_q;
  assign Result2 = result2_q;
endmodule

// File: tb/tb_mcycle_unit.sv
// tb/tb_mcycle_unit.sv - scoreboard bench for mcycle_unit with directed vectors.
module tb_mcycle_unit;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET, Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1, Operand2;
  logic [W-1:0] Result1, Result2;
  logic         Busy;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    int           len;
    bit           b2b;
    int           tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;
  bit   prev_b2b = 1'b0;

  task automatic check(input string nm, input int tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (op %0d): got %h, expected %h", nm, tag, act, exp);
    end
  endtask

  function automatic int exp_len(input logic [1:0] op, input logic [W-1:0] b);
    int n;
    logic [W-1:0] m;
    n = W;
`ifdef MCYCLE_EARLY_TERM_EN
    if (!op[1]) begin
      m = (!op[0] && b[W-1]) ? -b : b;
      n = 1;
      for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    end
`else
    m = b;
    if (op[1] && m[0]) n = W;
`endif
    return n + 1;
  endfunction

  always @(negedge CLK) begin
    if (RESET) begin
      busy_cnt = 0;
    end else if (Busy) begin
      busy_cnt++;
      if (q.size() > 0 && q[0].b2b && busy_cnt == q[0].len + 1) begin
        check("result1_b2b", q[0].tag, Result1, q[0].r1);
        check("result2_b2b", q[0].tag, Result2, q[0].r2);
        void'(q.pop_front());
        busy_cnt = 1;
      end
    end else if (busy_cnt > 0) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_completion: got busy run %0d, expected none", busy_cnt);
      end else begin
        check("result1", q[0].tag, Result1, q[0].r1);
        check("result2", q[0].tag, Result2, q[0].r2);
        check("busy_cycles", q[0].tag, W'(busy_cnt), W'(q[0].len));
        void'(q.pop_front());
      end
      busy_cnt = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got Busy=1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    if (!prev_b2b) repeat (2) begin @(posedge CLK); #1; end
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    @(posedge CLK); #1;
    Start = 1'b0; MCycleOp = 2'($urandom); Operand1 = $urandom; Operand2 = $urandom;
  endtask

  task automatic issue(input int tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r1, input logic [W-1:0] r2, input bit b2b);
    exp_t e;
    e.r1 = r1; e.r2 = r2; e.len = exp_len(op, b); e.b2b = b2b; e.tag = tag;
    q.push_back(e);
    launch(op, a, b);
    prev_b2b = b2b;
  endtask

  initial begin
    int n;
    RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    check("reset_busy", 0, W'(Busy), '0);
    check("reset_result1", 0, Result1, '0);
    check("reset_result2", 0, Result2, '0);

    issue(1,  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0);
    issue(2,  2'b00, -32'sd3,      32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 0);
    issue(3,  2'b00, 32'd5,        32'd1,        32'd5,        32'd0,        0);
    issue(4,  2'b00, -32'sd4,      -32'sd5,      32'd20,       32'd0,        0);
    issue(5,  2'b10, -32'sd7,      32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    issue(6,  2'b10, 32'd7,        -32'sd2,      32'hFFFFFFFD, 32'd1,        0);
    issue(7,  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0);
    issue(8,  2'b11, 32'd100,      32'd0,        32'hFFFFFFFF, 32'd100,      0);
    issue(9,  2'b10, -32'sd5,      32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 0);
    issue(10, 2'b11, 32'd100,      32'd7,        32'd14,       32'd2,        0);
    issue(11, 2'b01, 32'h12345678, 32'h10,       32'h23456780, 32'd1,        0);

    issue(12, 2'b01, 32'd3, 32'h80000000, 32'h80000000, 32'd1, 0);
    repeat (3) begin @(posedge CLK); #1; end
    Start = 1'b1; MCycleOp = 2'b11; Operand1 = 32'd9; Operand2 = 32'd3;
    @(posedge CLK); #1;
    Start = 1'b0;

    issue(13, 2'b11, 32'd1000, 32'd10, 32'd100, 32'd0, 1);
    issue(14, 2'b01, 32'd6,    32'd7,  32'd42,  32'd0, 0);

    launch(2'b11, 32'hFFFFFFFF, 32'd3);
    repeat (8) begin @(posedge CLK); #1; end
    RESET = 1'b1;
    #1;
    check("abort_busy", 15, W'(Busy), '0);
    check("abort_result1", 15, Result1, '0);
    check("abort_result2", 15, Result2, '0);
    repeat (2) begin @(posedge CLK); #1; end
    RESET = 1'b0;

    issue(16, 2'b00, -32'sd1, -32'sd1, 32'd1, 32'd0, 0);

    wait_idle();
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    repeat (3) @(posedge CLK);
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
